// File: rtl/fetch_pc_if.sv
// fetch_pc_if: bundles the icache request/response, hazard/redirect/halt
// controls and the IF/ID latch payload of the instruction-fetch stage.
// The master modport is the fetch stage; the slave modport is its
// surroundings (icache, hazard unit, later stages, IF/ID latch).
interface fetch_pc_if;
  // icache side
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  // hazard unit and later stages
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  // IF/ID latch
  logic        ifid_wen;
  logic        ifid_flush;
  logic [31:0] ifid_imemload;
  logic [31:0] ifid_imemaddr;

  modport master (
    input  ihit,
    input  imemload,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output imemREN,
    output imemaddr,
    output ifid_wen,
    output ifid_flush,
    output ifid_imemload,
    output ifid_imemaddr
  );

  modport slave (
    output ihit,
    output imemload,
    output stall,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  imemREN,
    input  imemaddr,
    input  ifid_wen,
    input  ifid_flush,
    input  ifid_imemload,
    input  ifid_imemaddr
  );
endinterface

// File: rtl/fetch_pc.sv
// fetch_pc: instruction-fetch stage. Owns the PC, issues the icache read,
// and produces write-enable/flush/payload for the IF/ID latch. Handles
// stalls, taken branch/jump redirects (deferred while an icache miss is
// outstanding) and a terminal halt state left only through reset.
//
// Optional build macro FETCH_PERF_EN adds two free-running performance
// counters, fetch_count and miss_cycles, as extra output ports.
module fetch_pc #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  fetch_pc_if.master  fif
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_cycles
`endif
);

  // Front-end control states
  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_WAIT_REDIR = 2'd1;
  localparam logic [1:0] ST_HALTED     = 2'd2;

  logic [31:0] pc_q,      pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  state_q,   state_d;

  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;
  logic        wen_c;
  logic        flush_c;

  // Sequential successor wraps naturally at 2^32.
  assign pc_plus4  = pc_q + 32'd4;
  // Redirect targets are word aligned; the low two bits are dropped.
  assign redir_tgt = fif.redirect_pc & 32'hFFFF_FFFC;

  // Next-state and IF/ID control: halt > redirect > stall > hit/miss.
  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    state_d   = state_q;
    wen_c     = 1'b0;
    flush_c   = 1'b0;

    if (state_q == ST_HALTED) begin
      // Parked: keep feeding bubbles downstream forever.
      wen_c   = 1'b1;
      flush_c = 1'b1;
    end else if (fif.halt) begin
      state_d = ST_HALTED;
      wen_c   = 1'b1;
      flush_c = 1'b1;
    end else if (state_q == ST_WAIT_REDIR) begin
      // The icache is still busy with the stale PC; the newest redirect
      // target wins, and the word that eventually returns is thrown away.
      if (fif.redirect_valid) begin
        pend_pc_d = redir_tgt;
      end
      if (fif.redirect_valid || !fif.stall) begin
        wen_c   = 1'b1;
        flush_c = 1'b1;
        if (fif.ihit) begin
          pc_d    = fif.redirect_valid ? redir_tgt : pend_pc_q;
          state_d = ST_RUN;
        end
      end
    end else begin
      // RUN (any unused encoding also behaves as RUN and self-recovers)
      state_d = ST_RUN;
      if (fif.redirect_valid) begin
        wen_c   = 1'b1;
        flush_c = 1'b1;
        if (fif.ihit) begin
          pc_d = redir_tgt;
        end else begin
          // Cannot abandon the in-flight miss; remember where to go.
          pend_pc_d = redir_tgt;
          state_d   = ST_WAIT_REDIR;
        end
      end else if (fif.stall) begin
        wen_c   = 1'b0;
        flush_c = 1'b0;
      end else if (fif.ihit) begin
        pc_d    = pc_plus4;
        wen_c   = 1'b1;
        flush_c = 1'b0;
      end else begin
        // Miss: push a bubble so decode does not see a stale word.
        wen_c   = 1'b1;
        flush_c = 1'b1;
      end
    end
  end

  // PC, pending redirect and control state, asynchronously reset.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pc_q      <= PC_INIT;
      pend_pc_q <= 32'h0000_0000;
      state_q   <= ST_RUN;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      state_q   <= state_d;
    end
  end

  // Outputs: icache request from registered state, IF/ID pass-throughs.
  assign fif.imemaddr      = pc_q;
  assign fif.imemREN       = (state_q != ST_HALTED);
  assign fif.ifid_wen      = wen_c   & nRst;
  assign fif.ifid_flush    = flush_c & nRst;
  assign fif.ifid_imemload = fif.imemload;
  assign fif.ifid_imemaddr = pc_plus4;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] miss_cycles_q, miss_cycles_d;
  logic        fetch_inc;
  logic        miss_inc;

  assign fetch_inc = (state_q == ST_RUN) && fif.ihit && !fif.stall &&
                     !fif.redirect_valid && !fif.halt;
  assign miss_inc  = fif.imemREN && !fif.ihit;

  // Counter increments; both wrap at 2^32.
  always_comb begin
    fetch_count_d = fetch_count_q;
    miss_cycles_d = miss_cycles_q;
    if (fetch_inc) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (miss_inc) begin
      miss_cycles_d = miss_cycles_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fetch_count_q <= 32'h0000_0000;
      miss_cycles_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
      miss_cycles_q <= miss_cycles_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign miss_cycles = miss_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed bench for fetch_pc. Inputs change on the falling
// edge, outputs are sampled 1 time unit later; the PC updates on the
// rising edge in between.
module tb_fetch_pc;
  logic clk = 1'b0;
  logic nRst;
  int   vectors     = 0;
  int   miscompares = 0;

  fetch_pc_if fif();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] miss_cycles;
`endif

  fetch_pc #(.PC_INIT(32'h0000_0000)) dut (
    .clk  (clk),
    .nRst (nRst),
    .fif  (fif)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .miss_cycles (miss_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: got no finish, want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    fif.ihit           = 1'b0;
    fif.imemload       = 32'h0;
    fif.stall          = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'h0;
    fif.halt           = 1'b0;
  endtask

  // Redirect with a hit: pc equals tgt at the next falling edge.
  task automatic goto_pc(input logic [31:0] tgt);
    idle_inputs();
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = tgt;
    fif.ihit           = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    nRst = 1'b1;
    fif.ihit = 1'b1;
    #1;
    nRst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (fif.imemaddr !== 32'h0 || fif.imemREN !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_req got addr=%h ren=%b want addr=00000000 ren=1", fif.imemaddr, fif.imemREN);
      end
      vectors++;
      if (fif.ifid_wen !== 1'b0 || fif.ifid_flush !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ifid got wen=%b flush=%b want wen=0 flush=0", fif.ifid_wen, fif.ifid_flush);
      end
      @(negedge clk);
    end
    nRst = 1'b1;
  endtask

  task automatic test_seq_hit();
    for (int i = 0; i < 3; i++) begin
      fif.ihit     = 1'b1;
      fif.imemload = 32'hA000_0000 + i;
      #1;
      vectors++;
      if (fif.imemaddr !== 32'(4 * i) || fif.ifid_imemaddr !== 32'(4 * i + 4)) begin
        miscompares++;
        $display("FAIL seq_addr[%0d] got addr=%h next=%h want addr=%h next=%h", i, fif.imemaddr, fif.ifid_imemaddr, 32'(4 * i), 32'(4 * i + 4));
      end
      vectors++;
      if (fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b0 || fif.ifid_imemload !== 32'hA000_0000 + i) begin
        miscompares++;
        $display("FAIL seq_ifid[%0d] got wen=%b flush=%b load=%h want wen=1 flush=0 load=%h", i, fif.ifid_wen, fif.ifid_flush, fif.ifid_imemload, 32'hA000_0000 + i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_miss();
    goto_pc(32'h10);
    for (int i = 0; i < 2; i++) begin
      fif.ihit = 1'b0;
      #1;
      vectors++;
      if (fif.imemaddr !== 32'h10 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
        miscompares++;
        $display("FAIL miss_bubble[%0d] got addr=%h wen=%b flush=%b want addr=00000010 wen=1 flush=1", i, fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
      end
      @(negedge clk);
    end
    fif.ihit = 1'b1;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h10 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_hit got addr=%h wen=%b flush=%b want addr=00000010 wen=1 flush=0", fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    fif.ihit = 1'b0;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h14) begin
      miscompares++;
      $display("FAIL miss_advance got addr=%h want addr=00000014", fif.imemaddr);
    end
  endtask

  task automatic test_stall();
    goto_pc(32'h20);
    for (int i = 0; i < 2; i++) begin
      fif.stall = 1'b1;
      fif.ihit  = 1'b1;
      #1;
      vectors++;
      if (fif.imemaddr !== 32'h20 || fif.ifid_wen !== 1'b0 || fif.ifid_flush !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got addr=%h wen=%b flush=%b want addr=00000020 wen=0 flush=0", i, fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
      end
      @(negedge clk);
    end
    fif.stall = 1'b0;
    fif.ihit  = 1'b1;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h20 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release got addr=%h wen=%b flush=%b want addr=00000020 wen=1 flush=0", fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    fif.ihit = 1'b0;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h24) begin
      miscompares++;
      $display("FAIL stall_advance got addr=%h want addr=00000024", fif.imemaddr);
    end
  endtask

  task automatic test_redirect_miss();
    // Redirect during a miss, then wait for the miss to finish.
    goto_pc(32'h30);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h103;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h30 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL redir_miss got addr=%h wen=%b flush=%b want addr=00000030 wen=1 flush=1", fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h30 || fif.imemREN !== 1'b1 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_stale got addr=%h ren=%b wen=%b flush=%b want addr=00000030 ren=1 wen=1 flush=1", fif.imemaddr, fif.imemREN, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    fif.stall = 1'b1;
    #1;
    vectors++;
    if (fif.ifid_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_stall got wen=%b want wen=0", fif.ifid_wen);
    end
    @(negedge clk);
    fif.stall = 1'b0;
    fif.ihit  = 1'b1;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h30 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_hit got addr=%h wen=%b flush=%b want addr=00000030 wen=1 flush=1", fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    fif.ihit = 1'b1;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h100 || fif.ifid_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_target got addr=%h flush=%b want addr=00000100 flush=0", fif.imemaddr, fif.ifid_flush);
    end
    @(negedge clk);

    // Second redirect while waiting overrides the first.
    goto_pc(32'h30);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h103;
    @(negedge clk);
    fif.redirect_pc    = 32'h200;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h30 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_redir2 got addr=%h wen=%b flush=%b want addr=00000030 wen=1 flush=1", fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    idle_inputs();
    fif.ihit = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h200) begin
      miscompares++;
      $display("FAIL wait_target2 got addr=%h want addr=00000200", fif.imemaddr);
    end

    // Redirect overrides a stall in RUN.
    goto_pc(32'h60);
    fif.stall          = 1'b1;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h82;
    fif.ihit           = 1'b1;
    #1;
    vectors++;
    if (fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL redir_stall got wen=%b flush=%b want wen=1 flush=1", fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h80) begin
      miscompares++;
      $display("FAIL redir_stall_target got addr=%h want addr=00000080", fif.imemaddr);
    end
  endtask

  task automatic test_wrap();
`ifdef FETCH_PERF_EN
    logic [31:0] fc_before;
`endif
    goto_pc(32'hFFFF_FFFC);
    fif.ihit = 1'b1;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'hFFFF_FFFC || fif.ifid_imemaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next got addr=%h next=%h want addr=fffffffc next=00000000", fif.imemaddr, fif.ifid_imemaddr);
    end
`ifdef FETCH_PERF_EN
    fc_before = fetch_count;
`endif
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc got addr=%h want addr=00000000", fif.imemaddr);
    end
`ifdef FETCH_PERF_EN
    vectors++;
    if (fetch_count !== fc_before + 32'd1) begin
      miscompares++;
      $display("FAIL wrap_fetch_count got %h want %h", fetch_count, fc_before + 32'd1);
    end
`endif
  endtask

  task automatic test_halt();
    goto_pc(32'h40);
    fif.halt = 1'b1;
    fif.ihit = 1'b1;
    #1;
    vectors++;
    if (fif.imemREN !== 1'b1 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_cycle got ren=%b wen=%b flush=%b want ren=1 wen=1 flush=1", fif.imemREN, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      fif.ihit           = 1'b1;
      fif.redirect_valid = (i == 1);
      fif.redirect_pc    = 32'h500;
      #1;
      vectors++;
      if (fif.imemREN !== 1'b0 || fif.imemaddr !== 32'h40 || fif.ifid_wen !== 1'b1 || fif.ifid_flush !== 1'b1) begin
        miscompares++;
        $display("FAIL halted[%0d] got ren=%b addr=%h wen=%b flush=%b want ren=0 addr=00000040 wen=1 flush=1", i, fif.imemREN, fif.imemaddr, fif.ifid_wen, fif.ifid_flush);
      end
      @(negedge clk);
    end
    idle_inputs();
    nRst = 1'b0;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h0 || fif.imemREN !== 1'b1 || fif.ifid_wen !== 1'b0 || fif.ifid_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_reset got addr=%h ren=%b wen=%b flush=%b want addr=00000000 ren=1 wen=0 flush=0", fif.imemaddr, fif.imemREN, fif.ifid_wen, fif.ifid_flush);
    end
    @(negedge clk);
    nRst = 1'b1;
    fif.ihit = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h4 || fif.imemREN !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_restart got addr=%h ren=%b want addr=00000004 ren=1", fif.imemaddr, fif.imemREN);
    end
  endtask

  task automatic test_reset_mid_wait();
    goto_pc(32'h50);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h300;
    @(negedge clk);
    idle_inputs();
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    fif.ihit = 1'b1;
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h0 || fif.ifid_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait_restart got addr=%h flush=%b want addr=00000000 flush=0", fif.imemaddr, fif.ifid_flush);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (fif.imemaddr !== 32'h4) begin
      miscompares++;
      $display("FAIL rst_wait_discard got addr=%h want addr=00000004", fif.imemaddr);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_seq_hit();
    test_miss();
    test_stall();
    test_redirect_miss();
    test_wrap();
    test_halt();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
